fp_special_case_pipe: RTL and testbench

Pipelined, parametrised special-case classifier and result-select resolver for the floating-point add/sub datapath. Classifies both operands (zero, subnormal, normal, inf, qNaN, sNaN) and computes the effective operation. Resolves sign/exponent/mantissa override selects and IEEE invalid flags. Sits beside the align/add/normalise path; the final result mux consumes its selects two cycles after operand acceptance, with valid/ready flow control.

---
 rtl/fp_pkg.sv | 42 ++++
 rtl/fp_classify_unit.sv | 16 +
 rtl/fp_special_case_pipe.sv | 137 +++++++++++++
 tb/tb_fp_special_case_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point special-case path:
// operand class encoding, override-select encoding and the classifier rule.
package fp_pkg;

    typedef enum logic [2:0] {
        FP_ZERO = 3'd0,
        FP_SUB  = 3'd1,
        FP_NORM = 3'd2,
        FP_INF  = 3'd3,
        FP_QNAN = 3'd4,
        FP_SNAN = 3'd5
    } fp_class_e;

    localparam logic [1:0] SEL_NORM = 2'b00;
    localparam logic [1:0] SEL_ZERO = 2'b01;
    localparam logic [1:0] SEL_ONE  = 2'b10;

    typedef struct packed {
        logic [1:0] sign;
        logic [1:0] exp;
        logic [1:0] man;
        logic       invalid;
    } fp_sel_t;

    // Field reductions are done by the caller so this stays width-independent.
    function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                              input logic frac_zero, input logic frac_msb,
                                              input logic ftz);
        fp_class_e c;
        if (exp_ones) begin
            if (frac_zero)     c = FP_INF;
            else if (frac_msb) c = FP_QNAN;
            else               c = FP_SNAN;
        end else if (exp_zero) begin
            c = (frac_zero || ftz) ? FP_ZERO : FP_SUB;
        end else begin
            c = FP_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_classify_unit.sv
// Combinational IEEE-754 operand classifier for one exponent/fraction pair.
module fp_classify_unit
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter bit FTZ   = 1'b0
) (
    input  logic [EXP_W-1:0] i_exp,
    input  logic [MAN_W-1:0] i_man,
    output fp_class_e        o_class
);

    assign o_class = fp_classify(&i_exp, ~|i_exp, ~|i_man, i_man[MAN_W-1], FTZ);

endmodule

// File: rtl/fp_special_case_pipe.sv
// Two-stage special-case classifier and override-select resolver for the
// FP add/sub datapath, with valid/ready flow control and a sticky invalid flag.
module fp_special_case_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter bit FTZ   = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_add_sub,
    input  logic             i_sign_a,
    input  logic             i_sign_b,
    input  logic [EXP_W-1:0] i_exp_a,
    input  logic [EXP_W-1:0] i_exp_b,
    input  logic [MAN_W-1:0] i_man_a,
    input  logic [MAN_W-1:0] i_man_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0]       o_sel_sign,
    output logic [1:0]       o_sel_exp,
    output logic [1:0]       o_sel_man,
    output logic             o_special,
    output logic [2:0]       o_class_a,
    output logic [2:0]       o_class_b,
    output logic             o_invalid,
    output logic             o_invalid_sticky,
    input  logic             i_clr_flags
);

    logic      vld_p1, vld_p2;
    logic      accept, adv_p2;
    fp_class_e class_a_c, class_b_c;
    fp_class_e class_a_p1, class_b_p1;
    logic      sign_a_p1, sign_b_eff_p1, eff_sub_p1;
    fp_sel_t   sel_c;

    // First matching rule wins: NaN/invalid, A inf, B inf, both zero.
    function automatic fp_sel_t resolve(input fp_class_e ca, input fp_class_e cb,
                                        input logic sa, input logic sbe, input logic es);
        fp_sel_t r;
        logic    any_nan, inf_inf, any_snan;
        r        = '{sign: SEL_NORM, exp: SEL_NORM, man: SEL_NORM, invalid: 1'b0};
        any_nan  = (ca == FP_QNAN) || (ca == FP_SNAN) || (cb == FP_QNAN) || (cb == FP_SNAN);
        any_snan = (ca == FP_SNAN) || (cb == FP_SNAN);
        inf_inf  = (ca == FP_INF) && (cb == FP_INF) && es;
        if (any_nan || inf_inf) begin
            r.sign    = SEL_ZERO;
            r.exp     = SEL_ONE;
            r.man     = SEL_ONE;
            r.invalid = any_snan || inf_inf;
        end else if (ca == FP_INF) begin
            r.sign = sa ? SEL_ONE : SEL_ZERO;
            r.exp  = SEL_ONE;
            r.man  = SEL_ZERO;
        end else if (cb == FP_INF) begin
            r.sign = sbe ? SEL_ONE : SEL_ZERO;
            r.exp  = SEL_ONE;
            r.man  = SEL_ZERO;
        end else if ((ca == FP_ZERO) && (cb == FP_ZERO)) begin
            // Exact cancellation rounds to +0 under round-to-nearest.
            r.sign = (!es && sa) ? SEL_ONE : SEL_ZERO;
            r.exp  = SEL_ZERO;
            r.man  = SEL_ZERO;
        end
        return r;
    endfunction

    fp_classify_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FTZ(FTZ)) u_cls_a (
        .i_exp   (i_exp_a),
        .i_man   (i_man_a),
        .o_class (class_a_c)
    );

    fp_classify_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FTZ(FTZ)) u_cls_b (
        .i_exp   (i_exp_b),
        .i_man   (i_man_b),
        .o_class (class_b_c)
    );

    assign o_ready = ~vld_p1 | ~vld_p2 | i_ready;
    assign accept  = i_valid & o_ready;
    assign adv_p2  = vld_p1 & (~vld_p2 | i_ready);
    assign o_valid = vld_p2;
    assign sel_c   = resolve(class_a_p1, class_b_p1, sign_a_p1, sign_b_eff_p1, eff_sub_p1);

    // Stage 1: operand classification and effective operation
    always_ff @(posedge i_clk) begin
        if (i_rst) vld_p1 <= 1'b0;
        else       vld_p1 <= accept | (vld_p1 & ~adv_p2);
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            class_a_p1    <= class_a_c;
            class_b_p1    <= class_b_c;
            sign_a_p1     <= i_sign_a;
            sign_b_eff_p1 <= i_sign_b ^ i_add_sub;
            eff_sub_p1    <= i_add_sub ^ i_sign_a ^ i_sign_b;
        end
    end

    // Stage 2: resolved selects, held while downstream stalls
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p2     <= 1'b0;
            o_sel_sign <= SEL_NORM;
            o_sel_exp  <= SEL_NORM;
            o_sel_man  <= SEL_NORM;
            o_special  <= 1'b0;
            o_class_a  <= 3'd0;
            o_class_b  <= 3'd0;
            o_invalid  <= 1'b0;
        end else begin
            vld_p2 <= adv_p2 | (vld_p2 & ~i_ready);
            if (adv_p2) begin
                o_sel_sign <= sel_c.sign;
                o_sel_exp  <= sel_c.exp;
                o_sel_man  <= sel_c.man;
                o_special  <= |{sel_c.sign, sel_c.exp, sel_c.man};
                o_class_a  <= class_a_p1;
                o_class_b  <= class_b_p1;
                o_invalid  <= sel_c.invalid;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)                             o_invalid_sticky <= 1'b0;
        else if (vld_p2 & i_ready & o_invalid) o_invalid_sticky <= 1'b1;
        else if (i_clr_flags)                  o_invalid_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_fp_special_case_pipe.sv
// Bench for fp_special_case_pipe: a stream model checked every cycle against
// a default instance and a flush-to-zero instance, plus directed literal checks.
module tb_fp_special_case_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        i_clr_flags = 1'b0;
    logic [31:0] cur_a = 32'h0;
    logic [31:0] cur_b = 32'h0;
    logic        cur_op = 1'b0;

    logic        o_ready, o_valid, o_special, o_invalid, o_invalid_sticky;
    logic [1:0]  o_sel_sign, o_sel_exp, o_sel_man;
    logic [2:0]  o_class_a, o_class_b;
    logic        f_ready, f_valid, f_special, f_invalid, f_sticky;
    logic [1:0]  f_sel_sign, f_sel_exp, f_sel_man;
    logic [2:0]  f_class_a, f_class_b;

    int n_tests = 0;
    int n_fail  = 0;
    int delivered = 0;
    bit chk_en = 0;
    bit bp_done = 0;
    bit exp_sticky = 0;
    bit fire, fire_inv;
    logic [13:0] q_n[$];
    logic [13:0] q_f[$];
    logic [13:0] got_n, got_f;

    always #5 i_clk = ~i_clk;

    fp_special_case_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(1'b0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_add_sub(cur_op), .i_sign_a(cur_a[31]), .i_sign_b(cur_b[31]),
        .i_exp_a(cur_a[30:23]), .i_exp_b(cur_b[30:23]),
        .i_man_a(cur_a[22:0]), .i_man_b(cur_b[22:0]),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_sel_sign(o_sel_sign), .o_sel_exp(o_sel_exp), .o_sel_man(o_sel_man),
        .o_special(o_special), .o_class_a(o_class_a), .o_class_b(o_class_b),
        .o_invalid(o_invalid), .o_invalid_sticky(o_invalid_sticky),
        .i_clr_flags(i_clr_flags)
    );

    fp_special_case_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(1'b1)) dut_ftz (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(f_ready),
        .i_add_sub(cur_op), .i_sign_a(cur_a[31]), .i_sign_b(cur_b[31]),
        .i_exp_a(cur_a[30:23]), .i_exp_b(cur_b[30:23]),
        .i_man_a(cur_a[22:0]), .i_man_b(cur_b[22:0]),
        .o_valid(f_valid), .i_ready(i_ready),
        .o_sel_sign(f_sel_sign), .o_sel_exp(f_sel_exp), .o_sel_man(f_sel_man),
        .o_special(f_special), .o_class_a(f_class_a), .o_class_b(f_class_b),
        .o_invalid(f_invalid), .o_invalid_sticky(f_sticky),
        .i_clr_flags(i_clr_flags)
    );

    assign got_n = {o_class_a, o_class_b, o_sel_sign, o_sel_exp, o_sel_man, o_special, o_invalid};
    assign got_f = {f_class_a, f_class_b, f_sel_sign, f_sel_exp, f_sel_man, f_special, f_invalid};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] cls_of(input logic [31:0] w, input bit ftz);
        if (w[30:23] == 8'hFF) return (w[22:0] == 0) ? 3'd3 : (w[22] ? 3'd4 : 3'd5);
        if (w[30:23] == 8'h00) return ((w[22:0] == 0) || ftz) ? 3'd0 : 3'd1;
        return 3'd2;
    endfunction

    // Expected {class_a, class_b, sign, exp, man, special, invalid} for one beat.
    function automatic logic [13:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic op, input bit ftz);
        logic [2:0] ca, cb;
        logic [1:0] s, e, m;
        logic       inv, eff, sb_eff, nan, infinf;
        ca = cls_of(a, ftz);
        cb = cls_of(b, ftz);
        eff = op ^ a[31] ^ b[31];
        sb_eff = b[31] ^ op;
        nan = (ca >= 3'd4) || (cb >= 3'd4);
        infinf = (ca == 3'd3) && (cb == 3'd3) && eff;
        s = 2'b00; e = 2'b00; m = 2'b00; inv = 1'b0;
        if (nan || infinf) begin
            s = 2'b01; e = 2'b10; m = 2'b10;
            inv = (ca == 3'd5) || (cb == 3'd5) || infinf;
        end else if (ca == 3'd3) begin
            s = a[31] ? 2'b10 : 2'b01; e = 2'b10; m = 2'b01;
        end else if (cb == 3'd3) begin
            s = sb_eff ? 2'b10 : 2'b01; e = 2'b10; m = 2'b01;
        end else if (ca == 3'd0 && cb == 3'd0) begin
            s = (!eff && a[31]) ? 2'b10 : 2'b01; e = 2'b01; m = 2'b01;
        end
        return {ca, cb, s, e, m, (s != 0) || (e != 0) || (m != 0), inv};
    endfunction

    always @(negedge i_clk) begin
        if (chk_en) begin
            fire = o_valid && i_ready;
            fire_inv = 1'b0;
            if (o_valid) begin
                if (q_n.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    chk("stream", {18'd0, got_n}, {18'd0, q_n[0]});
                    fire_inv = q_n[0][0];
                end
            end
            if (f_valid) begin
                if (q_f.size() == 0) chk("spurious_valid_ftz", 1, 0);
                else chk("stream_ftz", {18'd0, got_f}, {18'd0, q_f[0]});
            end
            chk("o_ready", o_ready, !(q_n.size() == 2 && !i_ready));
            chk("sticky", o_invalid_sticky, exp_sticky);
            chk("sticky_ftz", f_sticky, exp_sticky);
            if (i_rst) exp_sticky = 0;
            else if (fire && fire_inv) exp_sticky = 1;
            else if (i_clr_flags) exp_sticky = 0;
            if (fire && q_n.size() > 0) begin
                void'(q_n.pop_front());
                delivered++;
            end
            if (f_valid && i_ready && q_f.size() > 0) void'(q_f.pop_front());
            if (i_valid && o_ready && !i_rst) begin
                q_n.push_back(model(cur_a, cur_b, cur_op, 0));
                q_f.push_back(model(cur_a, cur_b, cur_op, 1));
            end
            if (i_rst) begin
                q_n.delete();
                q_f.delete();
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
        int n;
        n = 0;
        cur_a = a; cur_b = b; cur_op = op; i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) chk("send_timeout", 0, 1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic op, input bit use_ftz, input logic [13:0] exp);
        send(a, b, op);
        @(posedge i_clk);
        @(negedge i_clk);
        chk({name, "_latency"}, use_ftz ? f_valid : o_valid, 1);
        chk(name, {18'd0, use_ftz ? got_f : got_n}, {18'd0, exp});
        @(posedge i_clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("reset_valid", o_valid, 0);
        chk("reset_ready", o_ready, 1);
        chk("reset_sticky", o_invalid_sticky, 0);
        chk("reset_sel", {26'd0, got_n[7:2]}, 0);
        chk_en = 1;

        run_lit("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 0, {3'd3, 3'd3, 2'b01, 2'b10, 2'b10, 1'b1, 1'b1});
        chk("sticky_set", o_invalid_sticky, 1);
        i_clr_flags = 1'b1;
        @(posedge i_clk); #1;
        i_clr_flags = 1'b0;
        chk("sticky_clr", o_invalid_sticky, 0);

        run_lit("snan_a", 32'h7F800001, 32'h3F800000, 1'b0, 0, {3'd5, 3'd2, 2'b01, 2'b10, 2'b10, 1'b1, 1'b1});
        run_lit("qnan_a", 32'h7FC00000, 32'h3F800000, 1'b0, 0, {3'd4, 3'd2, 2'b01, 2'b10, 2'b10, 1'b1, 1'b0});
        i_clr_flags = 1'b1;
        @(posedge i_clk); #1;
        i_clr_flags = 1'b0;
        run_lit("pz_sub_pz", 32'h00000000, 32'h00000000, 1'b1, 0, {3'd0, 3'd0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0});
        run_lit("nz_add_nz", 32'h80000000, 32'h80000000, 1'b0, 0, {3'd0, 3'd0, 2'b10, 2'b01, 2'b01, 1'b1, 1'b0});
        run_lit("pz_add_nz", 32'h00000000, 32'h80000000, 1'b0, 0, {3'd0, 3'd0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0});
        run_lit("one_sub_inf", 32'h3F800000, 32'h7F800000, 1'b1, 0, {3'd2, 3'd3, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0});
        run_lit("one_add_two", 32'h3F800000, 32'h40000000, 1'b0, 0, {3'd2, 3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
        run_lit("ftz_sub_zero", 32'h00000001, 32'h80000000, 1'b0, 1, {3'd0, 3'd0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0});
        run_lit("noftz_sub", 32'h00000001, 32'h80000000, 1'b0, 0, {3'd1, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
        run_lit("inf_add_ninf_b", 32'hFF800000, 32'h3F800000, 1'b0, 0, {3'd3, 3'd2, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0});

        // Backpressure: four back-to-back beats against a stalled consumer.
        d0 = delivered;
        i_ready = 1'b0;
        fork
            begin
                send(32'h7F800000, 32'hFF800000, 1'b0);
                send(32'h3F800000, 32'h40000000, 1'b0);
                send(32'h00000000, 32'h00000000, 1'b1);
                send(32'h3F800000, 32'h7F800000, 1'b1);
                bp_done = 1;
            end
        join_none
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        chk("bp_ready_low", o_ready, 0);
        chk("bp_valid_held", o_valid, 1);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        n = 0;
        while (!(bp_done && q_n.size() == 0) && n < 60) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("bp_drained", bp_done && q_n.size() == 0, 1);
        chk("bp_count", delivered - d0, 4);

        // Reset with two beats in flight.
        cur_a = 32'h7F800000; cur_b = 32'hFF800000; cur_op = 1'b0; i_valid = 1'b1;
        @(posedge i_clk); #1;
        cur_a = 32'h7F800001; cur_b = 32'h3F800000;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("rst_valid", o_valid, 0);
        chk("rst_sticky", o_invalid_sticky, 0);
        repeat (6) @(posedge i_clk);
        #1;
        chk("rst_no_stale", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
